sd_cmd_sequencer: RTL and testbench

//  Sequences the SPI-mode SD byte engine: power-up dummy clocks, CMD0/CMD8/ACMD41/CMD16 init, then
//  CMD17 single-block reads on request. Drives the engine's 48-bit command frame and start strobe,

---
 rtl/sd_pkg.sv | 66 ++++++
 rtl/sd_crc7.sv | 17 +
 rtl/sd_cmd_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD command sequencer.
// The SD_CRC7_EN build computes CRC7 per frame; otherwise the fixed CRC values below are used.
package sd_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP, ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD16,
    ST_READY, ST_CMD17, ST_TOKEN, ST_DATA, ST_CRC, ST_ERROR
  } state_t;

  // Sub-phase of every command frame exchange.
  typedef enum logic [1:0] {PH_SEND, PH_ECHO, PH_POLL, PH_TAIL} phase_t;

  localparam logic [5:0]  IDX_CMD0   = 6'd0;
  localparam logic [5:0]  IDX_CMD8   = 6'd8;
  localparam logic [5:0]  IDX_CMD55  = 6'd55;
  localparam logic [5:0]  IDX_ACMD41 = 6'd41;
  localparam logic [5:0]  IDX_CMD16  = 6'd16;
  localparam logic [5:0]  IDX_CMD17  = 6'd17;

  localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
  localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;

  localparam logic [7:0]  TOKEN_START = 8'hFE;
  localparam logic [7:0]  R1_IDLE     = 8'h01;
  localparam logic [7:0]  R1_READY    = 8'h00;
  localparam logic [7:0]  CMD8_CHECK  = 8'hAA;

  localparam int ECHO_BYTES      = 6;
  localparam int CMD8_TAIL_BYTES = 4;
  localparam int DATA_CRC_BYTES  = 2;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_CMD0   = 3'd1;
  localparam logic [2:0] ERR_CMD8   = 3'd2;
  localparam logic [2:0] ERR_ACMD41 = 3'd3;
  localparam logic [2:0] ERR_CMD16  = 3'd4;
  localparam logic [2:0] ERR_CMD17  = 3'd5;
  localparam logic [2:0] ERR_TOKEN  = 3'd6;

  localparam logic [6:0] CRC_CMD0 = 7'h4A;
  localparam logic [6:0] CRC_CMD8 = 7'h43;
  localparam logic [6:0] CRC_NONE = 7'h00;

  function automatic logic [6:0] fixedCrc(input logic [5:0] idx);
    case (idx)
      IDX_CMD0: return CRC_CMD0;
      IDX_CMD8: return CRC_CMD8;
      default:  return CRC_NONE;
    endcase
  endfunction

  // A CMD55 failure is reported as an ACMD41 init failure.
  function automatic logic [2:0] stateErr(input state_t s);
    case (s)
      ST_CMD0:   return ERR_CMD0;
      ST_CMD8:   return ERR_CMD8;
      ST_CMD55:  return ERR_ACMD41;
      ST_ACMD41: return ERR_ACMD41;
      ST_CMD16:  return ERR_CMD16;
      ST_CMD17:  return ERR_CMD17;
      ST_TOKEN:  return ERR_TOKEN;
      default:   return ERR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Combinational SD CRC7 (x^7 + x^3 + 1) over the first 40 bits of a command frame.
module sd_crc7 (
  input  logic [39:0] msg,
  output logic [6:0]  crc
);
  logic fb;

  always_comb begin
    crc = '0;
    fb  = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb  = msg[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
  end
endmodule

// File: rtl/sd_cmd_sequencer.sv
// SPI-mode SD init/read sequencer driving the byte engine; streams 512-byte blocks out.
// Define SD_CRC7_EN to compute CRC7 per frame instead of using fixed CRC fields.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int NCR_MAX      = 8,
  parameter int ACMD41_TRIES = 1000,
  parameter int TOKEN_MAX    = 4096,
  parameter int BLOCK_LEN    = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ready,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        block_done,
  output logic        init_done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [47:0] eng_cmd,
  output logic        eng_start,
  input  logic        eng_rsp_toggle,
  input  logic [7:0]  eng_rsp
);
  localparam int POLL_MAX = (TOKEN_MAX > NCR_MAX) ? TOKEN_MAX : NCR_MAX;
  localparam int POLL_W   = $clog2(POLL_MAX + 1);
  localparam int BYTE_W   = $clog2(BLOCK_LEN + 1);
  localparam int RETRY_W  = $clog2(ACMD41_TRIES + 1);

  localparam logic [POLL_W-1:0]  NCR_LAST   = POLL_W'(NCR_MAX - 1);
  localparam logic [POLL_W-1:0]  TOKEN_LAST = POLL_W'(TOKEN_MAX - 1);
  localparam logic [BYTE_W-1:0]  ECHO_LAST  = BYTE_W'(ECHO_BYTES - 1);
  localparam logic [BYTE_W-1:0]  TAIL_LAST  = BYTE_W'(CMD8_TAIL_BYTES - 1);
  localparam logic [BYTE_W-1:0]  BLOCK_LAST = BYTE_W'(BLOCK_LEN - 1);
  localparam logic [BYTE_W-1:0]  CRC_LAST   = BYTE_W'(DATA_CRC_BYTES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(ACMD41_TRIES - 1);

  state_t              state, stateNxt;
  phase_t              phase, phaseNxt;
  logic                pwrSecond, pwrSecondNxt;
  logic [BYTE_W-1:0]   byteCnt, byteCntNxt;
  logic [POLL_W-1:0]   pollCnt, pollCntNxt;
  logic [RETRY_W-1:0]  retryCnt, retryCntNxt;
  logic [31:0]         addrLat, addrLatNxt;
  logic                togglePrev;
  logic                rdReadyNxt, dataValidNxt, blockDoneNxt, initDoneNxt, errorNxt, engStartNxt;
  logic [7:0]          dataOutNxt;
  logic [2:0]          errCodeNxt;
  logic [47:0]         engCmdNxt, frame;
  logic [5:0]          cmdIdx;
  logic [31:0]         cmdArg;
  logic [6:0]          cmdCrc;
  logic                evt, fail, isCmdState;

  always_comb begin
    cmdIdx = IDX_CMD0;
    cmdArg = '0;
    case (state)
      ST_CMD8:   begin cmdIdx = IDX_CMD8;   cmdArg = ARG_CMD8;        end
      ST_CMD55:  begin cmdIdx = IDX_CMD55;  cmdArg = '0;              end
      ST_ACMD41: begin cmdIdx = IDX_ACMD41; cmdArg = ARG_ACMD41;      end
      ST_CMD16:  begin cmdIdx = IDX_CMD16;  cmdArg = 32'(BLOCK_LEN);  end
      ST_CMD17:  begin cmdIdx = IDX_CMD17;  cmdArg = addrLat;         end
      default: ;
    endcase
  end

`ifdef SD_CRC7_EN
  sd_crc7 uCrc (
    .msg({2'b01, cmdIdx, cmdArg}),
    .crc(cmdCrc)
  );
`else
  assign cmdCrc = fixedCrc(cmdIdx);
`endif

  // Power-up frames are all ones so the card just sees clocks with MOSI high.
  assign frame = (state == ST_PWRUP) ? '1 : {2'b01, cmdIdx, cmdArg, cmdCrc, 1'b1};
  assign evt   = (eng_rsp_toggle != togglePrev);
  assign isCmdState = state inside {ST_PWRUP, ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD16, ST_CMD17};

  always_comb begin
    stateNxt     = state;
    phaseNxt     = phase;
    pwrSecondNxt = pwrSecond;
    byteCntNxt   = byteCnt;
    pollCntNxt   = pollCnt;
    retryCntNxt  = retryCnt;
    addrLatNxt   = addrLat;
    rdReadyNxt   = rd_ready;
    dataOutNxt   = data_out;
    dataValidNxt = 1'b0;
    blockDoneNxt = 1'b0;
    initDoneNxt  = init_done;
    errorNxt     = error;
    errCodeNxt   = err_code;
    engCmdNxt    = eng_cmd;
    engStartNxt  = 1'b0;
    fail         = 1'b0;

    if (isCmdState) begin
      case (phase)
        PH_SEND: begin
          engCmdNxt   = frame;
          engStartNxt = 1'b1;
          phaseNxt    = PH_ECHO;
          byteCntNxt  = '0;
        end
        PH_ECHO: if (evt) begin
          byteCntNxt = byteCnt + 1'b1;
          if (byteCnt == ECHO_LAST) begin
            byteCntNxt = '0;
            if (state == ST_PWRUP) begin
              phaseNxt     = PH_SEND;
              pwrSecondNxt = ~pwrSecond;
              if (pwrSecond) stateNxt = ST_CMD0;
            end else begin
              phaseNxt   = PH_POLL;
              pollCntNxt = '0;
            end
          end
        end
        PH_POLL: if (evt) begin
          if (!eng_rsp[7]) begin
            case (state)
              ST_CMD0:  if (eng_rsp == R1_IDLE) stateNxt = ST_CMD8; else fail = 1'b1;
              ST_CMD8:  if (eng_rsp == R1_IDLE) begin
                          phaseNxt   = PH_TAIL;
                          byteCntNxt = '0;
                        end else fail = 1'b1;
              ST_CMD55: stateNxt = ST_ACMD41;
              ST_ACMD41:
                if (eng_rsp == R1_READY) stateNxt = ST_CMD16;
                else if (eng_rsp == R1_IDLE && retryCnt != RETRY_LAST) begin
                  retryCntNxt = retryCnt + 1'b1;
                  stateNxt    = ST_CMD55;
                end else fail = 1'b1;
              ST_CMD16: if (eng_rsp == R1_READY) begin
                          stateNxt    = ST_READY;
                          initDoneNxt = 1'b1;
                          rdReadyNxt  = 1'b1;
                        end else fail = 1'b1;
              ST_CMD17: if (eng_rsp == R1_READY) begin
                          stateNxt   = ST_TOKEN;
                          pollCntNxt = '0;
                        end else fail = 1'b1;
              default: ;
            endcase
          end else if (pollCnt == NCR_LAST) begin
            fail = 1'b1;
          end else begin
            pollCntNxt = pollCnt + 1'b1;
          end
        end
        PH_TAIL: if (evt) begin
          byteCntNxt = byteCnt + 1'b1;
          if (byteCnt == TAIL_LAST) begin
            if (eng_rsp == CMD8_CHECK) stateNxt = ST_CMD55;
            else fail = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      case (state)
        ST_READY: if (rd_req && rd_ready) begin
          addrLatNxt = rd_addr;
          rdReadyNxt = 1'b0;
          stateNxt   = ST_CMD17;
        end
        ST_TOKEN: if (evt) begin
          if (eng_rsp == TOKEN_START) begin
            stateNxt   = ST_DATA;
            byteCntNxt = '0;
          end else if (eng_rsp[7:4] == 4'h0 || pollCnt == TOKEN_LAST) begin
            fail = 1'b1;
          end else begin
            pollCntNxt = pollCnt + 1'b1;
          end
        end
        ST_DATA: if (evt) begin
          dataOutNxt   = eng_rsp;
          dataValidNxt = 1'b1;
          byteCntNxt   = byteCnt + 1'b1;
          if (byteCnt == BLOCK_LAST) begin
            stateNxt   = ST_CRC;
            byteCntNxt = '0;
          end
        end
        ST_CRC: if (evt) begin
          byteCntNxt = byteCnt + 1'b1;
          if (byteCnt == CRC_LAST) begin
            blockDoneNxt = 1'b1;
            rdReadyNxt   = 1'b1;
            stateNxt     = ST_READY;
          end
        end
        default: ;
      endcase
    end

    if (fail) begin
      stateNxt   = ST_ERROR;
      errorNxt   = 1'b1;
      errCodeNxt = stateErr(state);
      rdReadyNxt = 1'b0;
    end
    if (stateNxt != state) phaseNxt = PH_SEND;
  end

  always_ff @(posedge clk) begin
    togglePrev <= eng_rsp_toggle;
    if (reset) begin
      state      <= ST_PWRUP;
      phase      <= PH_SEND;
      pwrSecond  <= 1'b0;
      byteCnt    <= '0;
      pollCnt    <= '0;
      retryCnt   <= '0;
      addrLat    <= '0;
      rd_ready   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      block_done <= 1'b0;
      init_done  <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      eng_cmd    <= '1;
      eng_start  <= 1'b0;
    end else begin
      state      <= stateNxt;
      phase      <= phaseNxt;
      pwrSecond  <= pwrSecondNxt;
      byteCnt    <= byteCntNxt;
      pollCnt    <= pollCntNxt;
      retryCnt   <= retryCntNxt;
      addrLat    <= addrLatNxt;
      rd_ready   <= rdReadyNxt;
      data_out   <= dataOutNxt;
      data_valid <= dataValidNxt;
      block_done <= blockDoneNxt;
      init_done  <= initDoneNxt;
      error      <= errorNxt;
      err_code   <= errCodeNxt;
      eng_cmd    <= engCmdNxt;
      eng_start  <= engStartNxt;
    end
  end
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: a scripted card/engine model answers each frame.
module tb_sd_cmd_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_ready, data_valid, block_done, init_done, error, eng_start;
  logic [7:0]  data_out;
  logic [2:0]  err_code;
  logic [47:0] eng_cmd;
  logic        eng_rsp_toggle = 1'b0;
  logic [7:0]  eng_rsp = 8'h00;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(
    .NCR_MAX(8), .ACMD41_TRIES(4), .TOKEN_MAX(4096), .BLOCK_LEN(512)
  ) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .data_out(data_out), .data_valid(data_valid), .block_done(block_done),
    .init_done(init_done), .error(error), .err_code(err_code), .eng_cmd(eng_cmd),
    .eng_start(eng_start), .eng_rsp_toggle(eng_rsp_toggle), .eng_rsp(eng_rsp)
  );

  int vectors = 0;
  int miscompares = 0;
  int bdCount = 0;
  int startCount = 0;
  logic [7:0]  dvLog[$];
  logic [7:0]  rspQ[$];
  logic [47:0] cmd0Frame, cmd8Frame, cmd16Frame;

  always @(negedge clk) begin
    if (data_valid) dvLog.push_back(data_out);
    if (block_done) bdCount++;
    if (eng_start) startCount++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sendByte(input logic [7:0] b);
    eng_rsp = b;
    eng_rsp_toggle = ~eng_rsp_toggle;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic waitStart(output bit got, output logic [47:0] cmd);
    got = 1'b0;
    cmd = '0;
    for (int i = 0; i < 200; i++) begin
      if (eng_start === 1'b1) begin
        got = 1'b1;
        cmd = eng_cmd;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Echo bytes have bit7 clear so a miscounted echo phase would be taken as an R1.
  task automatic exch(output bit got, output logic [47:0] cmd);
    waitStart(got, cmd);
    if (got) begin
      for (int i = 0; i < 6; i++) sendByte(8'h00);
      foreach (rspQ[i]) sendByte(rspQ[i]);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic doPreamble(output bit ok);
    bit got;
    logic [47:0] c;
    ok = 1'b1;
    for (int f = 0; f < 2; f++) begin
      rspQ = {};
      exch(got, c);
      if (!got || c !== 48'hFFFF_FFFF_FFFF) ok = 1'b0;
    end
    rspQ = '{8'hFF, 8'h01};
    exch(got, cmd0Frame);
    if (!got) ok = 1'b0;
    rspQ = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    exch(got, cmd8Frame);
    if (!got) ok = 1'b0;
  endtask

  task automatic doInit(input int pairs, output bit ok);
    bit got;
    logic [47:0] c;
    doPreamble(ok);
    for (int p = 0; p < pairs; p++) begin
      rspQ = '{8'h01};
      exch(got, c);
      if (!got || c[45:40] !== 6'd55) ok = 1'b0;
      if (p == pairs - 1) rspQ = '{8'h00};
      else rspQ = '{8'h01};
      exch(got, c);
      if (!got || c[45:40] !== 6'd41 || c[39:8] !== 32'h4000_0000) ok = 1'b0;
    end
    rspQ = '{8'h00};
    exch(got, cmd16Frame);
    if (!got) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({rd_ready, data_valid, block_done, init_done, error, eng_start, err_code, data_out} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rd_ready, data_valid, block_done, init_done, error, eng_start, err_code, data_out});
    end
    vectors++;
    if (eng_cmd !== 48'hFFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_eng_cmd: got %h expected ffffffffffff", eng_cmd);
    end
    reset = 1'b0;
  endtask

  task automatic test_init();
    bit ok;
    doInit(3, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL init_sequence: got %0b expected 1", ok); end
    vectors++;
    if (cmd0Frame !== 48'h4000_0000_0095) begin
      miscompares++; $display("FAIL cmd0_frame: got %h expected 400000000095", cmd0Frame);
    end
    vectors++;
    if (cmd8Frame !== 48'h4800_0001_AA87) begin
      miscompares++; $display("FAIL cmd8_frame: got %h expected 48000001aa87", cmd8Frame);
    end
    vectors++;
    if (cmd16Frame[47:8] !== 40'h50_0000_0200 || cmd16Frame[0] !== 1'b1) begin
      miscompares++; $display("FAIL cmd16_frame: got %h expected 5000000200xx", cmd16Frame);
    end
    vectors++;
    if ({init_done, rd_ready, error} !== 3'b110) begin
      miscompares++; $display("FAIL init_flags: got %b expected 110", {init_done, rd_ready, error});
    end
  endtask

  task automatic test_read();
    bit got;
    logic [47:0] c;
    int base, bdBase, bad;
    rd_addr = 32'h10;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    vectors++;
    if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL read_rdy_drop: got %b expected 0", rd_ready); end
    base = dvLog.size();
    bdBase = bdCount;
    rspQ = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    exch(got, c);
    vectors++;
    if (!got || c[47:8] !== 40'h51_0000_0010 || c[0] !== 1'b1) begin
      miscompares++; $display("FAIL cmd17_frame: got %h expected 5100000010xx", c);
    end
    for (int i = 0; i < 512; i++) sendByte(8'(i));
    vectors++;
    if (dvLog.size() - base != 512) begin
      miscompares++; $display("FAIL data_count: got %0d expected 512", dvLog.size() - base);
    end
    bad = 0;
    for (int i = 0; i < 512 && base + i < dvLog.size(); i++)
      if (dvLog[base + i] !== 8'(i)) bad++;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL data_order: got %0d wrong bytes expected 0", bad); end
    sendByte(8'h12);
    vectors++;
    if (bdCount != bdBase) begin
      miscompares++; $display("FAIL crc_first_byte: got %0d block_done expected 0", bdCount - bdBase);
    end
    sendByte(8'h34);
    vectors++;
    if (bdCount != bdBase + 1 || rd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL block_done: got %0d pulses rd_ready %b expected 1 and 1", bdCount - bdBase, rd_ready);
    end
    vectors++;
    if (dvLog.size() - base != 512) begin
      miscompares++; $display("FAIL crc_not_data: got %0d strobes expected 512", dvLog.size() - base);
    end
  endtask

  task automatic test_token_error();
    bit got;
    logic [47:0] c;
    int base;
    base = dvLog.size();
    rd_addr = 32'h5;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    rspQ = '{8'h00, 8'hFF, 8'h08};
    exch(got, c);
    vectors++;
    if (!got || {error, err_code, rd_ready} !== 5'b1_110_0) begin
      miscompares++;
      $display("FAIL token_error: got error %b code %0d rdy %b expected 1 6 0", error, err_code, rd_ready);
    end
    vectors++;
    if (dvLog.size() != base) begin
      miscompares++; $display("FAIL token_no_data: got %0d strobes expected 0", dvLog.size() - base);
    end
  endtask

  task automatic test_reset_mid_data();
    bit got, ok;
    logic [47:0] c;
    int base;
    doReset();
    doInit(1, ok);
    rd_addr = 32'h20;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    base = dvLog.size();
    rspQ = '{8'h00, 8'hFE};
    exch(got, c);
    for (int i = 0; i < 100; i++) sendByte(8'(i + 7));
    vectors++;
    if (!ok || dvLog.size() - base != 100) begin
      miscompares++; $display("FAIL mid_data_setup: got %0d strobes ok %b expected 100 1", dvLog.size() - base, ok);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rd_ready, data_valid, block_done, init_done, error, err_code, data_out} !== 16'h0 ||
        eng_cmd !== 48'hFFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL mid_data_reset: got %h cmd %h expected 0 ffffffffffff",
               {rd_ready, data_valid, block_done, init_done, error, err_code, data_out}, eng_cmd);
    end
    reset = 1'b0;
    base = dvLog.size();
    doInit(2, ok);
    vectors++;
    if (!ok || init_done !== 1'b1 || dvLog.size() != base) begin
      miscompares++;
      $display("FAIL reinit: got ok %b init_done %b strobes %0d expected 1 1 0", ok, init_done, dvLog.size() - base);
    end
  endtask

  task automatic test_cmd0_timeout();
    bit got, ok;
    logic [47:0] c;
    int s;
    doReset();
    for (int f = 0; f < 2; f++) begin rspQ = {}; exch(got, c); end
    rspQ = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exch(got, c);
    vectors++;
    if (!got || error !== 1'b0) begin
      miscompares++; $display("FAIL cmd0_seven_ff: got error %b started %b expected 0 1", error, got);
    end
    sendByte(8'hFF);
    vectors++;
    if ({error, err_code, init_done} !== 5'b1_001_0) begin
      miscompares++;
      $display("FAIL cmd0_timeout: got error %b code %0d init %b expected 1 1 0", error, err_code, init_done);
    end
    s = startCount;
    repeat (50) @(negedge clk);
    vectors++;
    if (startCount != s) begin
      miscompares++; $display("FAIL cmd0_no_restart: got %0d starts expected 0", startCount - s);
    end
    ok = got;
  endtask

  task automatic test_acmd41_exhaust();
    bit got, ok;
    logic [47:0] c;
    int pairs, s;
    doReset();
    doPreamble(ok);
    pairs = 0;
    for (int p = 0; p < 4; p++) begin
      rspQ = '{8'h01};
      exch(got, c);
      exch(got, c);
      if (got && c[45:40] === 6'd41) pairs++;
    end
    vectors++;
    if (!ok || pairs != 4) begin
      miscompares++; $display("FAIL acmd41_pairs: got %0d pairs ok %b expected 4 1", pairs, ok);
    end
    vectors++;
    if ({error, err_code, init_done} !== 5'b1_011_0) begin
      miscompares++;
      $display("FAIL acmd41_exhaust: got error %b code %0d init %b expected 1 3 0", error, err_code, init_done);
    end
    s = startCount;
    repeat (50) @(negedge clk);
    vectors++;
    if (startCount != s) begin
      miscompares++; $display("FAIL acmd41_fifth_pair: got %0d starts expected 0", startCount - s);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_token_error();
    test_reset_mid_data();
    test_cmd0_timeout();
    test_acmd41_exhaust();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
